// File: rtl/lc3b_scoreboard.sv
// lc3b_scoreboard: pending-write hazard scoreboard for the LC-3b decode stage.
// One saturating-free up/down counter per architectural register plus one for
// the condition codes. Decode stalls on RAW hazards or when a destination
// counter is already at its maximum; retire and kill both release entries.
// Optional build macro SCB_RETIRE_BYPASS_EN: a source whose only pending
// writer retires this cycle is considered ready (regfile write-through and
// CC forwarding make the value available in the same cycle).
module lc3b_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic                        issue_hold,
    input  logic [$clog2(NUM_REGS)-1:0] sr1_id,
    input  logic                        sr1_needed,
    input  logic [$clog2(NUM_REGS)-1:0] sr2_id,
    input  logic                        sr2_needed,
    input  logic                        cc_needed,
    input  logic [$clog2(NUM_REGS)-1:0] dr_id,
    input  logic                        dr_ld_reg,
    input  logic                        dr_ld_cc,
    input  logic                        retire_valid,
    input  logic [$clog2(NUM_REGS)-1:0] retire_drid,
    input  logic                        retire_ld_reg,
    input  logic                        retire_ld_cc,
    input  logic                        kill_valid,
    input  logic [$clog2(NUM_REGS)-1:0] kill_drid,
    input  logic                        kill_ld_reg,
    input  logic                        kill_ld_cc,
    output logic                        dep_stall,
    output logic                        issue_fire,
    output logic [NUM_REGS-1:0]         busy_vec,
    output logic                        cc_busy,
    output logic                        underflow_err
);

    localparam int ID_W = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt      [NUM_REGS];
    logic [CNT_W-1:0] cnt_next [NUM_REGS];
    logic [CNT_W-1:0] cc_cnt;
    logic [CNT_W-1:0] cc_next;
    logic             sr1_busy;
    logic             sr2_busy;
    logic             cc_src_busy;
    logic             dr_full;
    logic             any_uflow;
    logic [CNT_W:0]   reg_step;
    logic [CNT_W:0]   cc_step;

    // One counter update: returns {underflow, new_value}. The increment is
    // applied before the decrements so an issue and a retire on the same
    // entry cancel without ever dipping below zero.
    function automatic logic [CNT_W:0] step(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec_a,
        input logic             dec_b
    );
        logic [CNT_W+1:0] up;
        logic [CNT_W+1:0] down;
        up   = {2'b00, cur} + {{(CNT_W+1){1'b0}}, inc};
        down = {{(CNT_W+1){1'b0}}, dec_a} + {{(CNT_W+1){1'b0}}, dec_b};
        if (down > up) begin
            step = {1'b1, {CNT_W{1'b0}}};
        end else begin
            step = {1'b0, CNT_W'(up - down)};
        end
    endfunction

    // Hazard detection from the registered counters (before this cycle's updates).
    always_comb begin
        sr1_busy    = sr1_needed && (cnt[sr1_id] != '0);
        sr2_busy    = sr2_needed && (cnt[sr2_id] != '0);
        cc_src_busy = cc_needed && (cc_cnt != '0);
`ifdef SCB_RETIRE_BYPASS_EN
        if (retire_valid && retire_ld_reg) begin
            if ((retire_drid == sr1_id) && (cnt[sr1_id] == CNT_ONE)) sr1_busy = 1'b0;
            if ((retire_drid == sr2_id) && (cnt[sr2_id] == CNT_ONE)) sr2_busy = 1'b0;
        end
        if (retire_valid && retire_ld_cc && (cc_cnt == CNT_ONE)) cc_src_busy = 1'b0;
`endif
        // Structural limit: another writer would overflow the counter.
        dr_full = (dr_ld_reg && (cnt[dr_id] == CNT_MAX)) ||
                  (dr_ld_cc && (cc_cnt == CNT_MAX));
    end

    assign dep_stall  = issue_valid & (sr1_busy | sr2_busy | cc_src_busy | dr_full);
    assign issue_fire = issue_valid & ~dep_stall & ~issue_hold;

    // Next counter values and underflow detection for every entry.
    always_comb begin
        any_uflow = 1'b0;
        reg_step  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_step = step(cnt[i],
                            issue_fire && dr_ld_reg && (dr_id == ID_W'(i)),
                            retire_valid && retire_ld_reg && (retire_drid == ID_W'(i)),
                            kill_valid && kill_ld_reg && (kill_drid == ID_W'(i)));
            cnt_next[i] = reg_step[CNT_W-1:0];
            any_uflow   = any_uflow | reg_step[CNT_W];
        end
        cc_step   = step(cc_cnt, issue_fire && dr_ld_cc,
                         retire_valid && retire_ld_cc, kill_valid && kill_ld_cc);
        cc_next   = cc_step[CNT_W-1:0];
        any_uflow = any_uflow | cc_step[CNT_W];
    end

    // Counter state and sticky underflow flag; reset discards all pending writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            cc_cnt        <= '0;
            underflow_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_next[i];
            cc_cnt        <= cc_next;
            underflow_err <= underflow_err | any_uflow;
        end
    end

    // Per-register busy flags for observation and debug.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) busy_vec[i] = (cnt[i] != '0);
    end

    assign cc_busy = (cc_cnt != '0);

endmodule

// File: tb/tb_lc3b_scoreboard.sv
// Testbench for lc3b_scoreboard: directed scenarios with literal expectations
// followed by randomized traffic, all checked against an integer-count model.
module tb_lc3b_scoreboard;

`ifdef SCB_RETIRE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int CMAX = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid, issue_hold;
    logic [2:0] sr1_id, sr2_id, dr_id, retire_drid, kill_drid;
    logic       sr1_needed, sr2_needed, cc_needed, dr_ld_reg, dr_ld_cc;
    logic       retire_valid, retire_ld_reg, retire_ld_cc;
    logic       kill_valid, kill_ld_reg, kill_ld_cc;
    logic       dep_stall, issue_fire, cc_busy, underflow_err;
    logic [7:0] busy_vec;

    int model_cnt [8];
    int model_cc  = 0;
    bit model_err = 1'b0;
    int n_checks  = 0;
    int n_fail    = 0;

    lc3b_scoreboard #(.NUM_REGS(8), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_hold(issue_hold),
        .sr1_id(sr1_id), .sr1_needed(sr1_needed),
        .sr2_id(sr2_id), .sr2_needed(sr2_needed),
        .cc_needed(cc_needed), .dr_id(dr_id),
        .dr_ld_reg(dr_ld_reg), .dr_ld_cc(dr_ld_cc),
        .retire_valid(retire_valid), .retire_drid(retire_drid),
        .retire_ld_reg(retire_ld_reg), .retire_ld_cc(retire_ld_cc),
        .kill_valid(kill_valid), .kill_drid(kill_drid),
        .kill_ld_reg(kill_ld_reg), .kill_ld_cc(kill_ld_cc),
        .dep_stall(dep_stall), .issue_fire(issue_fire),
        .busy_vec(busy_vec), .cc_busy(cc_busy), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a source is blocked while any older writer is outstanding.
    function automatic bit src_blocked(input bit needed, input int id);
        bit blk;
        blk = needed && (model_cnt[id] != 0);
        if (BYP && model_cnt[id] == 1 && retire_valid && retire_ld_reg && int'(retire_drid) == id)
            blk = 1'b0;
        return blk;
    endfunction

    function automatic bit cc_blocked();
        bit blk;
        blk = cc_needed && (model_cc != 0);
        if (BYP && model_cc == 1 && retire_valid && retire_ld_cc) blk = 1'b0;
        return blk;
    endfunction

    // Compare process: check outputs mid-cycle, then advance the model.
    always @(negedge clk) begin
        bit   exp_stall, exp_fire;
        logic [7:0] exp_busy;
        int   nxt;
        if (reset) begin
            for (int r = 0; r < 8; r++) model_cnt[r] = 0;
            model_cc  = 0;
            model_err = 1'b0;
        end
        exp_stall = issue_valid && (src_blocked(sr1_needed, int'(sr1_id)) ||
                                    src_blocked(sr2_needed, int'(sr2_id)) || cc_blocked() ||
                                    (dr_ld_reg && model_cnt[dr_id] == CMAX) ||
                                    (dr_ld_cc && model_cc == CMAX));
        exp_fire  = issue_valid && !exp_stall && !issue_hold;
        for (int r = 0; r < 8; r++) exp_busy[r] = (model_cnt[r] != 0);
        chk("dep_stall", 32'(dep_stall), 32'(exp_stall));
        chk("issue_fire", 32'(issue_fire), 32'(exp_fire));
        chk("busy_vec", 32'(busy_vec), 32'(exp_busy));
        chk("cc_busy", 32'(cc_busy), 32'(model_cc != 0));
        chk("underflow_err", 32'(underflow_err), 32'(model_err));
        if (!reset) begin
            for (int r = 0; r < 8; r++) begin
                nxt = model_cnt[r] + int'(exp_fire && dr_ld_reg && int'(dr_id) == r)
                      - int'(retire_valid && retire_ld_reg && int'(retire_drid) == r)
                      - int'(kill_valid && kill_ld_reg && int'(kill_drid) == r);
                if (nxt < 0) begin nxt = 0; model_err = 1'b1; end
                model_cnt[r] = nxt;
            end
            nxt = model_cc + int'(exp_fire && dr_ld_cc) - int'(retire_valid && retire_ld_cc)
                  - int'(kill_valid && kill_ld_cc);
            if (nxt < 0) begin nxt = 0; model_err = 1'b1; end
            model_cc = nxt;
        end
    end

    task automatic clear_inputs();
        issue_valid = 0; issue_hold = 0;
        sr1_id = 0; sr2_id = 0; dr_id = 0;
        sr1_needed = 0; sr2_needed = 0; cc_needed = 0; dr_ld_reg = 0; dr_ld_cc = 0;
        retire_valid = 0; retire_drid = 0; retire_ld_reg = 0; retire_ld_cc = 0;
        kill_valid = 0; kill_drid = 0; kill_ld_reg = 0; kill_ld_cc = 0;
    endtask

    // Advance to the drive point just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_reg(input logic [2:0] d);
        clear_inputs();
        issue_valid = 1; dr_ld_reg = 1; dr_id = d;
    endtask

    task automatic retire_reg(input logic [2:0] d);
        clear_inputs();
        retire_valid = 1; retire_ld_reg = 1; retire_drid = d;
    endtask

    task automatic rand_inputs();
        int list[$];
        int avail;
        clear_inputs();
        issue_valid = ($urandom_range(0, 9) < 7);
        issue_hold  = ($urandom_range(0, 9) < 2);
        sr1_id = 3'($urandom_range(0, 7)); sr1_needed = 1'($urandom_range(0, 1));
        sr2_id = 3'($urandom_range(0, 7)); sr2_needed = 1'($urandom_range(0, 1));
        cc_needed = ($urandom_range(0, 3) == 0);
        dr_id = 3'($urandom_range(0, 7));
        dr_ld_reg = ($urandom_range(0, 3) != 0);
        dr_ld_cc  = 1'($urandom_range(0, 1));
        for (int r = 0; r < 8; r++) if (model_cnt[r] > 0) list.push_back(r);
        if ($urandom_range(0, 9) < 5) begin
            retire_valid = 1;
            if (list.size() > 0) begin
                retire_ld_reg = 1;
                retire_drid = 3'(list[$urandom_range(0, list.size() - 1)]);
            end
            retire_ld_cc = (model_cc > 0) && ($urandom_range(0, 1) == 1);
        end
        list = {};
        for (int r = 0; r < 8; r++) begin
            avail = model_cnt[r] - int'(retire_valid && retire_ld_reg && int'(retire_drid) == r);
            if (avail > 0) list.push_back(r);
        end
        if ($urandom_range(0, 9) < 2) begin
            kill_valid = 1;
            if (list.size() > 0) begin
                kill_ld_reg = 1;
                kill_drid = 3'(list[$urandom_range(0, list.size() - 1)]);
            end
            kill_ld_cc = (model_cc - int'(retire_valid && retire_ld_cc) > 0) &&
                         ($urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) model_cnt[r] = 0;
        clear_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("lit_reset_busy", 32'(busy_vec), 32'h0);
        chk("lit_reset_uflow", 32'(underflow_err), 32'h0);

        // RAW on R3: writer then reader.
        issue_reg(3'd3); #1;
        chk("lit_raw_first_fire", 32'(issue_fire), 32'h1);
        tick();
        issue_reg(3'd1); sr1_needed = 1; sr1_id = 3'd3; #1;
        chk("lit_raw_stall", 32'(dep_stall), 32'h1);
        tick(); #1;
        chk("lit_raw_stall_hold", 32'(dep_stall), 32'h1);
        retire_valid = 1; retire_ld_reg = 1; retire_drid = 3'd3; #1;
        chk("lit_raw_retire_cycle", 32'(dep_stall), 32'(!BYP));
        tick();
        retire_valid = 0; retire_ld_reg = 0; #1;
        chk("lit_raw_released", 32'(dep_stall), 32'h0);
        issue_valid = !BYP;
        tick();
        retire_reg(3'd1); #1;
        chk("lit_raw_r1_busy", 32'(busy_vec), 32'h02);
        tick();
        clear_inputs(); #1;
        chk("lit_raw_clean", 32'(busy_vec), 32'h0);

        // Three writers to R5 fill its counter; the fourth is blocked.
        for (int k = 0; k < 3; k++) begin
            issue_reg(3'd5); #1;
            chk("lit_r5_fire", 32'(issue_fire), 32'h1);
            tick();
        end
        issue_reg(3'd5); #1;
        chk("lit_r5_busy", 32'(busy_vec), 32'h20);
        chk("lit_r5_full_stall", 32'(dep_stall), 32'h1);
        chk("lit_r5_full_nofire", 32'(issue_fire), 32'h0);
        for (int k = 0; k < 3; k++) begin
            retire_reg(3'd5);
            tick();
        end
        clear_inputs(); #1;
        chk("lit_r5_drained", 32'(busy_vec), 32'h0);

        // Issue and retire on R2 in the same cycle keep the count at 1.
        issue_reg(3'd2);
        tick();
        issue_reg(3'd2); retire_valid = 1; retire_ld_reg = 1; retire_drid = 3'd2;
        tick();
        clear_inputs(); #1;
        chk("lit_r2_same_cycle", 32'(busy_vec), 32'h04);
        retire_reg(3'd2);
        tick();
        clear_inputs();

        // CC writer then BR; kill the writer.
        issue_valid = 1; dr_ld_cc = 1;
        tick();
        clear_inputs(); issue_valid = 1; cc_needed = 1; #1;
        chk("lit_cc_busy", 32'(cc_busy), 32'h1);
        chk("lit_cc_stall", 32'(dep_stall), 32'h1);
        kill_valid = 1; kill_ld_cc = 1;
        tick();
        kill_valid = 0; kill_ld_cc = 0; #1;
        chk("lit_cc_killed", 32'(cc_busy), 32'h0);
        chk("lit_br_fires", 32'(issue_fire), 32'h1);
        tick();

        // Reset mid-stream with two writers pending on R3.
        issue_reg(3'd3); tick();
        issue_reg(3'd3); tick();
        clear_inputs(); #1;
        chk("lit_r3_two", 32'(busy_vec), 32'h08);
        reset = 1; #1;
        chk("lit_async_reset", 32'(busy_vec), 32'h0);
        tick(); tick();
        reset = 0;
        issue_valid = 1; sr1_needed = 1; sr1_id = 3'd3; #1;
        chk("lit_post_reset_stall", 32'(dep_stall), 32'h0);
        chk("lit_post_reset_uflow", 32'(underflow_err), 32'h0);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            tick();
        end

        // Clean reset, then underflow on R6.
        clear_inputs();
        reset = 1; tick(); reset = 0;
        retire_reg(3'd6);
        tick();
        clear_inputs(); #1;
        chk("lit_uflow_set", 32'(underflow_err), 32'h1);
        chk("lit_uflow_clamp", 32'(busy_vec), 32'h0);
        repeat (4) tick();
        chk("lit_uflow_sticky", 32'(underflow_err), 32'h1);
        reset = 1; #1;
        chk("lit_uflow_cleared", 32'(underflow_err), 32'h0);
        tick(); reset = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
